cyq_updown_counter_n: RTL
=========================

# cyq_updown_counter_n

Parametrised synchronous up/down counter, the next generation of the team's 74HC161-style 4-bit counter. It adds configurable width, a programmable modulus (BCD, mod-60, etc.), a direction input, and a selectable wrap or saturate mode. A registered one-cycle carry pulse lets counters be cascaded without extra glue. It sits in the counter/timer section of the SLC lab designs and is a drop-in generalisation of the 4-bit part.

## Interface
- WIDTH, 8, counter width in bits; must be ≥ 2.
- MODULUS, 2**WIDTH, count range 0..MODULUS-1; legal range 2 ≤ MODULUS ≤ 2**WIDTH.
- WRAP, 1, 1 = wrap at terminal; 0 = saturate and hold at terminal.
- clk  in  1  counter clock; all state changes on the rising edge.
- MR  in  1  master reset; asynchronous, active-low.
- Cep  in  1  count-enable (parallel); active-high.
- Cet  in  1  count-enable (trickle); active-high; also gates TC.
- PE  in  1  parallel load enable; active-low, synchronous.
- UD  in  1  direction: 1 = up, 0 = down.
- D  in  WIDTH  parallel load data.
- Q  out  WIDTH  counter state.
- TC  out  1  terminal count; combinational.
- RC  out  1  registered carry/borrow pulse for cascading.

## Operation
- Priority order:
  - MR low: asynchronously clears Q and RC.
  - Else PE low: loads D, regardless of Cep, Cet and UD.
  - Else Cep & Cet: counts.
  - Else: holds.
- The terminal value is MODULUS-1 when UD=1 and 0 when UD=0.
- Counting when Q is not at the terminal value: Q ± 1.
- Counting when Q is at the terminal value:
  - WRAP=1: up wraps to 0; down wraps to MODULUS-1.
  - WRAP=0: Q holds at the terminal value.
- Load clamp: if D ≥ MODULUS, Q loads MODULUS-1. This applies in both directions, so Q is never out of range.
- TC = Cet & (Q == terminal value for the current UD). Behaviour matches the 4-bit part when WIDTH=4, MODULUS=16, UD=1.
- RC is set for exactly one cycle on a clock edge where a count occurs with Q at the terminal value and WRAP=1. Otherwise RC is 0.
  - With WRAP=0, RC stays 0; TC alone indicates saturation.
- RC and a load: RC is 0 on any load edge, even when D equals the terminal value.
- Cascading: the upstream TC drives the downstream Cet; all stages share clk.
- Arithmetic is unsigned, modulo 2**WIDTH internally. The compare uses the MODULUS-1 constant sized to WIDTH.

## Timing
- Reset values: Q = 0 and RC = 0 while MR is low. TC = Cet & ~UD during reset, because Q=0 is the down terminal.
- MR deassertion must meet recovery to clk. The first count happens on the first rising edge after release.
- Load latency: 1 edge (D appears on Q after the edge where PE is sampled low).
- Count latency: 1 edge.
- TC follows Q, Cet and UD with combinational delay only; there is no register stage.
- RC is high during the cycle after the wrap edge, aligned with the wrapped Q value.
- A UD change between edges takes effect on the next edge. TC re-evaluates immediately.
- MR asserted mid-count aborts any pending load or count. Q clears without waiting for clk.
- Cep=1 with Cet=0 holds Q and forces TC=0.

## Structure
- Package cyq_cnt_pkg:
  - Direction constants CNT_UP=1 and CNT_DOWN=0.
  - Helper function clog2.
  - MODULUS range-check macro or assertion, used by elaboration.
- One sub-module, cyq_cnt_term. It is combinational and produces, from Q, UD and MODULUS:
  - at_terminal
  - next-count value
  - clamped load value
- The top level holds the Q and RC registers, the priority mux and the TC gating.
- Elaboration fails if MODULUS < 2 or MODULUS > 2**WIDTH.

## Test plan
- Reset and enables (WIDTH=4, MODULUS=10, WRAP=1):
  - Pulse MR low mid-count at Q=7 → Q=0 and RC=0 immediately, before the next clk edge.
  - Release MR with UD=1, Cep=Cet=1 → Q counts 1, 2, …, 9.
- BCD wrap (same config, UD=1):
  - From Q=9 → TC=1 while Q=9.
  - Next edge → Q=0 and RC=1 for one cycle.
  - Following edge → Q=1 and RC=0.
- Down wrap and clamp (same config):
  - PE=0 with D=12 → Q=9 (clamped), RC=0.
  - Set UD=0 → Q counts down 9 … 0; TC=1 at Q=0.
  - Next edge → Q=9 and RC=1.
- Saturate (WIDTH=8, MODULUS=256, WRAP=0):
  - Load D=253 with UD=1 → Q goes 254, then 255, then stays 255 for 5 more edges.
  - TC=1 throughout the hold; RC stays 0.
- Enable gating and priority (defaults):
  - Cep=1, Cet=0 → Q holds and TC=0.
  - PE=0 with Cep=Cet=0 and D=0x5A → Q=0x5A on the next edge.
  - PE=0 on the same edge as a would-be wrap → load wins and RC=0.
- Cascade (two WIDTH=4, MODULUS=10 instances; first TC to second Cet; UD=1):
  - After 100 edges from reset → pair reads 0/0.
  - First stage RC pulses 10 times; second stage RC pulses once.

Source files
------------

// File: rtl/cyq_cnt_pkg.sv
// cyq_cnt_pkg: direction constants and elaboration helpers for the up/down counter
package cyq_cnt_pkg;
  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DOWN = 1'b0;
  function automatic int clog2(input longint v);
    int r;
    longint x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction
  function automatic bit mod_ok(input int width, input longint modulus);
    return width >= 2 && modulus >= 2 && modulus <= (longint'(1) << width);
  endfunction
endpackage

// File: rtl/cyq_updown_counter_n_if.sv
// cyq_updown_counter_n_if: control, data and status bundle of the up/down counter
interface cyq_updown_counter_n_if #(parameter int WIDTH = 8);
  logic Cep;
  logic Cet;
  logic PE;
  logic UD;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic TC;
  logic RC;
  modport master(output Cep, Cet, PE, UD, D, input Q, TC, RC);
  modport slave(input Cep, Cet, PE, UD, D, output Q, TC, RC);
endinterface

// File: rtl/cyq_cnt_term.sv
// cyq_cnt_term: terminal detect, next count and clamped load value for one counter state
module cyq_cnt_term
  import cyq_cnt_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MODULUS = 2 ** WIDTH,
  parameter bit WRAP = 1'b1
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_ud,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_at_terminal,
  output logic [WIDTH-1:0] o_next,
  output logic [WIDTH-1:0] o_load
);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
  // terminal is the top of the range going up and zero going down; saturate mode parks there
  always_comb begin
    o_at_terminal = (i_ud == CNT_UP) ? (i_q == LAST) : (i_q == '0);
    o_next = o_at_terminal ? (WRAP ? ((i_ud == CNT_UP) ? '0 : LAST) : i_q)
                           : ((i_ud == CNT_UP) ? i_q + 1'b1 : i_q - 1'b1);
    o_load = (i_d > LAST) ? LAST : i_d;
  end
endmodule

// File: rtl/cyq_updown_counter_n.sv
// cyq_updown_counter_n: programmable-modulus up/down counter with wrap/saturate and cascade carry
module cyq_updown_counter_n
  import cyq_cnt_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MODULUS = 2 ** WIDTH,
  parameter bit WRAP = 1'b1
) (
  input logic clk,
  input logic MR,
  cyq_updown_counter_n_if.slave bus
);
  if (!mod_ok(WIDTH, MODULUS)) begin : g_bad_modulus
    $error("cyq_updown_counter_n: need WIDTH >= 2 and 2 <= MODULUS <= 2**WIDTH");
  end
  logic [WIDTH-1:0] r_q;
  logic             r_rc;
  logic             w_at_terminal;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_load;
  logic             w_count;
  assign w_count = bus.Cep & bus.Cet;
  cyq_cnt_term #(.WIDTH(WIDTH), .MODULUS(MODULUS), .WRAP(WRAP)) u_term (
    .i_q          (r_q),
    .i_ud         (bus.UD),
    .i_d          (bus.D),
    .o_at_terminal(w_at_terminal),
    .o_next       (w_next),
    .o_load       (w_load)
  );
  // reset > load > count > hold; carry pulses only on a wrapping count edge
  always_ff @(posedge clk or negedge MR) begin
    if (!MR) begin
      r_q  <= '0;
      r_rc <= 1'b0;
    end else if (!bus.PE) begin
      r_q  <= w_load;
      r_rc <= 1'b0;
    end else if (w_count) begin
      r_q  <= w_next;
      r_rc <= WRAP && w_at_terminal;
    end else begin
      r_rc <= 1'b0;
    end
  end
  assign bus.Q  = r_q;
  assign bus.RC = r_rc;
  assign bus.TC = bus.Cet & w_at_terminal;
endmodule
